// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply, restoring divide, one op in flight.
module ex_muldiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  MD_Start,
    input  logic                  MD_Flush,
    input  logic [2:0]            EX_Funct3,
    input  logic [DATA_WIDTH-1:0] EX_Rs1_Data,
    input  logic [DATA_WIDTH-1:0] EX_Rs2_Data,
    input  logic [ADDR_WIDTH-1:0] EX_Rd_Addr,
    output logic                  MD_Busy,
    output logic                  MD_Done,
    output logic [DATA_WIDTH-1:0] MD_Result,
    output logic [ADDR_WIDTH-1:0] MD_Rd_Addr
);
    localparam int W = DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                state_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [2:0]            f3_q;
    logic [ADDR_WIDTH-1:0] rd_q;
    logic                  neg_q;
    logic [W-1:0]          hi_q, lo_q, opb_q;
    logic [W-1:0]          res_q;
    logic [ADDR_WIDTH-1:0] rd_out_q;
    logic                  done_q;

    logic          a_neg, b_neg, neg_d;
    logic [W-1:0]  mag_a, mag_b;
    logic          fast;
    logic [W-1:0]  fast_val;
    logic [W:0]    sum, trial;
    logic [W-1:0]  hi_d, lo_d;
    logic [2*W-1:0] prod;
    logic [W-1:0]  div_sel;
    logic [W-1:0]  final_val;

    // Operand decode, fast-path detection and one datapath iteration
    always_comb begin
        a_neg    = 1'b0;
        b_neg    = 1'b0;
        fast     = 1'b0;
        fast_val = '0;
        unique case (EX_Funct3)
            3'd0, 3'd1, 3'd4, 3'd6: begin
                a_neg = EX_Rs1_Data[W-1];
                b_neg = EX_Rs2_Data[W-1];
            end
            3'd2: a_neg = EX_Rs1_Data[W-1];
            default: ;
        endcase
        neg_d = (EX_Funct3[2] & EX_Funct3[1]) ? a_neg : (a_neg ^ b_neg);
        mag_a = a_neg ? (W'(0) - EX_Rs1_Data) : EX_Rs1_Data;
        mag_b = b_neg ? (W'(0) - EX_Rs2_Data) : EX_Rs2_Data;

        // Zero divisor and signed overflow bypass the iteration
        if (EX_Funct3[2]) begin
            if (EX_Rs2_Data == '0) begin
                fast     = 1'b1;
                fast_val = EX_Funct3[1] ? EX_Rs1_Data : '1;
            end else if (!EX_Funct3[0]
                         && EX_Rs1_Data == {1'b1, {(W-1){1'b0}}}
                         && EX_Rs2_Data == '1) begin
                fast     = 1'b1;
                fast_val = EX_Funct3[1] ? '0 : EX_Rs1_Data;
            end
        end

        sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        trial = {hi_q, lo_q[W-1]} - {1'b0, opb_q};
        if (f3_q[2]) begin
            if (!trial[W]) begin
                hi_d = trial[W-1:0];
                lo_d = {lo_q[W-2:0], 1'b1};
            end else begin
                hi_d = {hi_q[W-2:0], lo_q[W-1]};
                lo_d = {lo_q[W-2:0], 1'b0};
            end
        end else begin
            hi_d = sum[W:1];
            lo_d = {sum[0], lo_q[W-1:1]};
        end

        prod    = neg_q ? ((2*W)'(0) - {hi_d, lo_d}) : {hi_d, lo_d};
        div_sel = f3_q[1] ? hi_d : lo_d;
        if (f3_q[2])
            final_val = neg_q ? (W'(0) - div_sel) : div_sel;
        else if (f3_q[1:0] == 2'd0)
            final_val = prod[W-1:0];
        else
            final_val = prod[2*W-1:W];
    end

    // Stall while starting or iterating; flush releases the pipeline
    always_comb begin
        MD_Busy = ~MD_Flush
                & (((state_q == IDLE) & MD_Start) | (state_q == CALC));
    end

    assign MD_Done    = done_q;
    assign MD_Result  = res_q;
    assign MD_Rd_Addr = rd_out_q;

    // Control FSM, iteration registers and registered result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            rd_q     <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
            res_q    <= '0;
            rd_out_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (MD_Flush) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                unique case (state_q)
                    IDLE: if (MD_Start) begin
                        f3_q  <= EX_Funct3;
                        rd_q  <= EX_Rd_Addr;
                        neg_q <= neg_d;
                        cnt_q <= '0;
                        if (fast) begin
                            res_q    <= fast_val;
                            rd_out_q <= EX_Rd_Addr;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            hi_q    <= '0;
                            lo_q    <= mag_a;
                            opb_q   <= mag_b;
                            state_q <= CALC;
                        end
                    end
                    CALC: begin
                        hi_q  <= hi_d;
                        lo_q  <= lo_d;
                        cnt_q <= cnt_q + CNT_WIDTH'(1);
                        if (cnt_q == CNT_WIDTH'(W - 1)) begin
                            res_q    <= final_val;
                            rd_out_q <= rd_q;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end
                    end
                    DONE:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage.
- Consumes operands, funct3 and destination register from the ID/EX pipeline register outputs.
- Stalls IF/ID/EX while computing, then presents a registered result for the EX/MEM register.
- One operation in flight. Radix-2 shift-add multiply and restoring divide, 32 iterations each.

Parameters:
- DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH.
- ADDR_WIDTH, 5, register address width.
- CNT_WIDTH, 6, iteration counter width; must hold DATA_WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- MD_Start  input  1  EX instruction is an M-extension op (funct7 = 0000001, opcode OP), control not flushed.
- MD_Flush  input  1  kill the current operation (branch mispredict / ID_EX flush).
- EX_Funct3  input  3  op select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- EX_Rs1_Data  input  DATA_WIDTH  rs1 operand (post-forwarding).
- EX_Rs2_Data  input  DATA_WIDTH  rs2 operand (post-forwarding).
- EX_Rd_Addr  input  ADDR_WIDTH  destination register.
- MD_Busy  output  1  stall request to hazard unit.
- MD_Done  output  1  result valid, one-cycle pulse.
- MD_Result  output  DATA_WIDTH  result.
- MD_Rd_Addr  output  ADDR_WIDTH  destination of MD_Result.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counter=0, internal registers=0, MD_Done=0, MD_Result=0, MD_Rd_Addr=0. MD_Busy=0 once MD_Start is low.
- States: IDLE, CALC, DONE.
- IDLE:
  - MD_Start=1 at edge E0: latch funct3, Rd and operand magnitudes (abs per signedness).
  - Record result-negate flag: MUL* = s1^s2 over signed operands; DIV = s1^s2; REM = s1.
  - Go to CALC with counter=0.
- Fast path at E0, straight to DONE (latency 1):
  - DIV/DIVU with rs2=0: result = all ones.
  - REM/REMU with rs2=0: result = rs1.
  - DIV with rs1=0x80000000 and rs2=0xFFFFFFFF: result = 0x80000000.
  - REM with the same operands: result = 0.
- CALC:
  - One iteration per edge. Counter increments; at counter=DATA_WIDTH-1 the next edge goes to DONE.
  - Normal op: E0 start, E1..E32 iterate, DONE during the cycle after E32.
  - Multiply: 64-bit accumulator {hi,lo}; add multiplicand when LSB set, then shift right.
  - Divide: shift remainder left, trial-subtract divisor, set quotient bit on non-negative.
- DONE:
  - MD_Done=1; MD_Result holds the final value, negated if the flag is set.
  - Result select: MUL = low word; MULH/MULHSU/MULHU = high word of the signed-corrected 64-bit product; DIV/DIVU = quotient; REM/REMU = remainder.
  - Next edge returns to IDLE unconditionally.
  - MD_Start is ignored in DONE: it still belongs to the completing instruction because ID_EX advances at that edge.
- MD_Busy (combinational) = (state==IDLE & MD_Start) | (state==CALC). It is 0 in DONE so the pipeline advances exactly at the completing edge.
- MD_Result and MD_Rd_Addr are registered. They hold their value after DONE until the next result is written.
- MD_Flush=1 at any edge: next state IDLE, counter=0, no MD_Done pulse, MD_Result unchanged.
  - Flush has priority over MD_Start and over completion.
  - MD_Busy is forced 0 while MD_Flush=1.
- Back-to-back ops: the second MD_Start is seen in IDLE the cycle after DONE. No bubble is required between ops.
- Reset asserted mid-CALC aborts immediately to the reset values.
- Arithmetic is modulo 2^64 for products. MULHSU treats rs2 as unsigned and never negates it.

Test Plan:
- MUL rs1=7, rs2=-3 (0xFFFFFFFD) → MD_Busy high for 33 cycles (E0 through E32). MD_Done at cycle 33, MD_Result=0xFFFFFFEB, MD_Rd_Addr=latched Rd.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULH same operands → 0x00000000. MULHSU rs1=-1, rs2=0xFFFFFFFF → 0xFFFFFFFF.
- DIV -20/3 → 0xFFFFFFFA (-6). REM -20/3 → 0xFFFFFFFE (-2). DIVU 100/7 → 14. REMU 100/7 → 2.
- Fast path, each with 1-cycle latency: DIVU 5/0 → 0xFFFFFFFF. REM 5/0 → 5. DIV 0x80000000/-1 → 0x80000000. REM same → 0.
- Flush at iteration 10 of a DIV → state IDLE next cycle, no MD_Done, MD_Result keeps its prior value. A new MUL 3×4 immediately after → 12.
- rst_n low mid-CALC → all outputs 0 asynchronously. After release with MD_Start=0: MD_Busy=0, no spurious MD_Done.
